// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter in front of a shared ripple-carry add/subtract unit.
// Each granted operation runs IDLE -> EXEC -> DONE, and the result is held until the next one completes.
module addsub_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             op0,
  input  logic             op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] s,
  output logic             ovr,
  output logic             cout,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e           state_q, state_d;
  logic             last_q, win_q, op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             any_req, pick;
  logic [WIDTH-1:0] sum, b_x;
  logic             carry, carry_msb;

  // On a tie, the requester that was not granted last wins.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) pick = ~last_q;
    else              pick = req1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StExec;
      StExec:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    b_x       = b_q ^ {WIDTH{op_q}};
    carry     = op_q;
    carry_msb = 1'b0;
    sum       = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) carry_msb = carry;
      sum[i] = a_q[i] ^ b_x[i] ^ carry;
      carry  = (a_q[i] & b_x[i]) | (carry & (a_q[i] ^ b_x[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s       <= '0;
      ovr     <= 1'b0;
      cout    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && any_req) begin
        win_q  <= pick;
        last_q <= pick;
        op_q   <= pick ? op1 : op0;
        a_q    <= pick ? a1 : a0;
        b_q    <= pick ? b1 : b0;
      end
      if (state_q == StExec) begin
        s    <= sum;
        ovr  <= carry ^ carry_msb;
        cout <= carry;
      end
    end
  end

  assign gnt0  = (state_q == StExec) && !win_q;
  assign gnt1  = (state_q == StExec) &&  win_q;
  assign done0 = (state_q == StDone) && !win_q;
  assign done1 = (state_q == StDone) &&  win_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_addsub_arbiter.sv
// Randomized bench for addsub_arbiter: a transaction-level model predicts grants, completions
// and arithmetic results from integer math, and every output is compared each cycle.
module tb_addsub_arbiter;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst, req0, req1, op0, op1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, done0, done1, ovr, cout, busy;
  logic [W-1:0] s;

  int n_vec = 0;
  int n_err = 0;

  // Model state: time since grant (0 none, 1 granted, 2 completing), plus the captured job.
  int           m_age;
  int           m_last, m_win;
  int           m_op, m_a, m_b;
  int           m_s, m_ovr, m_cout;

  addsub_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .s(s), .ovr(ovr), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
  endfunction

  // Advance the model by one rising edge using the inputs applied before it.
  task automatic model_step();
    int res;
    if (rst) begin
      m_age = 0; m_last = 1; m_win = 0;
      m_s = 0; m_ovr = 0; m_cout = 0;
    end else if (m_age == 0) begin
      if (req0 || req1) begin
        m_win  = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
        m_last = m_win;
        m_op   = m_win ? int'(op1) : int'(op0);
        m_a    = m_win ? int'(a1) : int'(a0);
        m_b    = m_win ? int'(b1) : int'(b0);
        m_age  = 1;
      end
    end else if (m_age == 1) begin
      res    = m_op ? to_signed(m_a) - to_signed(m_b) : to_signed(m_a) + to_signed(m_b);
      m_ovr  = (res > (1 << (W - 1)) - 1 || res < -(1 << (W - 1))) ? 1 : 0;
      m_s    = (m_op ? m_a - m_b : m_a + m_b) & ((1 << W) - 1);
      m_cout = m_op ? int'(m_a >= m_b) : int'(m_a + m_b > (1 << W) - 1);
      m_age  = 2;
    end else begin
      m_age = 0;
    end
  endtask

  task automatic compare_all();
    check("gnt0",  gnt0,  m_age == 1 && m_win == 0);
    check("gnt1",  gnt1,  m_age == 1 && m_win == 1);
    check("done0", done0, m_age == 2 && m_win == 0);
    check("done1", done1, m_age == 2 && m_win == 1);
    check("busy",  busy,  m_age != 0);
    check("s",     s,     m_s);
    check("ovr",   ovr,   m_ovr);
    check("cout",  cout,  m_cout);
  endtask

  task automatic cyc(input logic r, input logic q0, input logic p0, input logic [W-1:0] x0,
                     input logic [W-1:0] y0, input logic q1, input logic p1,
                     input logic [W-1:0] x1, input logic [W-1:0] y1);
    @(negedge clk);
    rst = r; req0 = q0; op0 = p0; a0 = x0; b0 = y0;
    req1 = q1; op1 = p1; a1 = x1; b1 = y1;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    m_age = 0; m_last = 1; m_win = 0; m_op = 0; m_a = 0; m_b = 0;
    m_s = 0; m_ovr = 0; m_cout = 0;

    // Reset, then 3 + 4 on requester 0.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 3, 4, 0, 0, 0, 0);
    check("add34_gnt0", gnt0, 1'b1);
    cyc(0, 0, 0, 9, 9, 0, 0, 0, 0);
    check("add34_s", s, 4'b0111);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // 2 - 5 on requester 1.
    cyc(0, 0, 0, 0, 0, 1, 1, 2, 5);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("sub25_s", s, 4'b1101);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Overflowing add, then a subtract with carry out; operands changed mid-flight.
    cyc(0, 1, 0, 7, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 2, 2, 0, 0, 0, 0);
    check("add71_ovr", ovr, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 5, 3, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("sub53_cout", cout, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Both held from reset: grants alternate.
    cyc(1, 1, 0, 1, 1, 1, 0, 2, 2);
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 1, 1, 1, 0, 2, 2);
    // Reset in the EXEC cycle aborts, and the next tie goes to requester 0.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 6, 6);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("abort_done1", done1, 1'b0);
    cyc(0, 1, 0, 4, 4, 1, 0, 5, 5);
    check("tie_after_rst", gnt0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 40) == 0, $urandom % 2, $urandom % 2, W'($urandom), W'($urandom),
          $urandom % 2, $urandom % 2, W'($urandom), W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
